trace_capture: RTL

//  Parametrised on-chip trace buffer for the TopLevel processor.
//  - Samples NUM_CH debug channels (ch0 = PCDisplay; then valueDisplay, CoordinateX_ID,

---
 rtl/trace_capture_pkg.sv | 27 ++
 rtl/trace_capture_ram.sv | 36 +++
 rtl/trace_capture.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/trace_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture_pkg
//  Purpose  : Shared FSM state encodings and a width helper for the trace
//             buffer (trace_capture / trace_capture_ram).
//  Revision : 1.0  initial release
// ============================================================================
package trace_capture_pkg;

  // Capture FSM states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    TR_IDLE = 2'd0,
    TR_PRE  = 2'd1,
    TR_POST = 2'd2,
    TR_DUMP = 2'd3
  } tr_state_t;

  // Smallest r with 2**r >= value (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_capture_ram.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture_ram
//  Purpose  : Simple dual-port trace storage, synchronous write and
//             registered read (block-RAM friendly). Read data is held while
//             rd_en is low, which lets the top use it as its output register.
//  Revision : 1.0  initial release
// ============================================================================
module trace_capture_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 128,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one sample per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered, updated only when a new entry is requested.
  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture
//  Purpose  : Circular trace buffer for NUM_CH debug channels. Arms, records
//             qualified samples, stops POST_TRIG samples after a PC match on
//             ch0 and then dumps the window oldest-first over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     capture_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_last,
  output logic                     triggered,
  output logic [1:0]               state_o
);

  localparam int AW    = clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int WIDTH = NUM_CH * DATA_W;

  tr_state_t      state, state_nxt;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fill, fill_inc, post_cnt, rd_cnt;
  logic           head_valid, head_last, trig_seen;
  logic           wr_en, trig_hit, enter_dump;
  logic           rd_issue, rd_fire, dump_done;
  logic [WIDTH-1:0] ram_q;

  assign trig_hit  = capture_en && trig_en && (ch_data[DATA_W-1:0] == trig_pc);
  assign fill_inc  = (fill == CW'(DEPTH)) ? fill : fill + 1'b1;
  assign rd_fire   = head_valid && rd_ready;
  assign dump_done = rd_fire && head_last;
  // Fetch the next entry whenever the RAM output register is empty or is
  // being consumed this cycle; this sustains one entry per cycle.
  assign rd_issue  = (state == TR_DUMP) && (rd_cnt < fill) && (!head_valid || rd_ready);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= TR_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and per-cycle write / dump-entry strobes.
  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    enter_dump = 1'b0;
    case (state)
      TR_IDLE: begin
        if (arm) state_nxt = TR_PRE;
      end
      TR_PRE: begin
        wr_en = capture_en;
        if (trig_hit) begin
          if (POST_TRIG == 0) begin
            state_nxt  = TR_DUMP;
            enter_dump = 1'b1;
          end else begin
            state_nxt  = TR_POST;
          end
        end
      end
      TR_POST: begin
        wr_en = capture_en;
        if (capture_en && (post_cnt == CW'(1))) begin
          state_nxt  = TR_DUMP;
          enter_dump = 1'b1;
        end
      end
      TR_DUMP: begin
        if (dump_done) state_nxt = TR_IDLE;
      end
      default: state_nxt = TR_IDLE;
    endcase
  end

  // Pointers, counters, trigger flag and the dump output-valid tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      trig_seen  <= 1'b0;
    end else begin
      if ((state == TR_IDLE) && arm) begin
        wr_ptr    <= '0;
        fill      <= '0;
        trig_seen <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill   <= fill_inc;
      end
      if ((state == TR_PRE) && trig_hit) begin
        trig_seen <= 1'b1;
        post_cnt  <= CW'(POST_TRIG);
      end
      if ((state == TR_POST) && capture_en) post_cnt <= post_cnt - 1'b1;
      // Dump entry always coincides with a write, so use the post-write
      // pointer/fill: a full buffer starts at the oldest slot (next write).
      if (enter_dump) begin
        rd_ptr <= (fill_inc == CW'(DEPTH)) ? (wr_ptr + 1'b1) : '0;
        rd_cnt <= '0;
      end
      if (rd_issue) begin
        rd_ptr     <= rd_ptr + 1'b1;
        rd_cnt     <= rd_cnt + 1'b1;
        head_last  <= ((rd_cnt + 1'b1) == fill);
        head_valid <= 1'b1;
      end else if (rd_fire) begin
        head_valid <= 1'b0;
      end
      if (dump_done) trig_seen <= 1'b0;
    end
  end

  trace_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (ch_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_q    (ram_q)
  );

  assign rd_valid  = head_valid;
  assign rd_data   = head_valid ? ram_q : '0;
  assign rd_last   = head_valid && head_last;
  assign triggered = trig_seen;
  assign state_o   = state;

endmodule
`default_nettype wire
